multicycle_sequencer: RTL
=========================

# multicycle_sequencer

Multicycle control sequencer for the processor core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and waits on the instruction-memory and data-memory ready handshakes. It drives the one-cycle write strobes and the mux selects consumed by the decode stage, register bank, ALU flag register and memory interfaces. It also keeps a retired-instruction counter and a sticky illegal-instruction flag.

## Interface
- RETIRE_W, 16, width of the retired-instruction counter

- CLK  in  1  clock; all state changes on the rising edge
- RST_N  in  1  reset, asynchronous, active-low
- INSTR_TYPE  in  3  instruction[31:29] from the instruction register; valid from DECODE onward
- INSTR_OP  in  5  instruction[28:24] from the instruction register
- COND  in  1  branch condition result from the flag logic; sampled in EXEC
- IMEM_READY  in  1  instruction memory has data this cycle
- DMEM_READY  in  1  data memory has completed the access this cycle
- IMEM_REQ  out  1  instruction fetch request
- DMEM_REQ  out  1  data memory request
- W_MI  out  1  instruction register load strobe
- W_PC  out  1  PC write strobe
- W_RB  out  1  register bank write strobe
- W_RF  out  1  flag register write strobe
- W_DM  out  1  data memory write enable; qualifies DMEM_REQ
- S_MXPC  out  1  0 = PC+1, 1 = branch/jump target
- S_MXRB  out  1  writeback source: 0 = ALU, 1 = memory data
- S_MXSE  out  1  ALU B source: 0 = PRB, 1 = sign-extended immediate
- OP_ALU  out  5  ALU operation; equals INSTR_OP in EXEC, 0 otherwise
- STATE  out  3  current state code
- ILLEGAL  out  1  sticky illegal-instruction flag
- RETIRE_CNT  out  RETIRE_W  count of retired instructions

## Operation
- State codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Type decode:
  - 000 ALU reg-reg
  - 001 ALU immediate
  - 010 load
  - 011 store
  - 100 conditional branch
  - 101 jump
  - 111 halt
  - 110 illegal
- FETCH
  - IMEM_REQ=1 throughout.
  - In the cycle IMEM_READY=1: W_MI=1, W_PC=1, S_MXPC=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE
  - Lasts one cycle; the register bank is read during this cycle.
  - Type 111 goes to HALT.
  - Type 110 sets ILLEGAL and goes to HALT.
  - All other types go to EXEC.
- EXEC
  - Lasts one cycle. S_MXSE=1 for types 001, 010 and 011.
  - Types 000 and 001: OP_ALU=INSTR_OP, W_RF=1, go to WB.
  - Types 010 and 011: OP_ALU=INSTR_OP (address add), go to MEM.
  - Type 100: S_MXPC=1, W_PC=COND, retire, go to FETCH.
  - Type 101: S_MXPC=1, W_PC=1, retire, go to FETCH.
- MEM
  - DMEM_REQ=1 held until DMEM_READY=1. W_DM=1 throughout for store, 0 for load.
  - On DMEM_READY, a store retires and goes to FETCH; a load goes to WB.
- WB
  - Lasts one cycle. W_RB=1; S_MXRB=1 for load, 0 for ALU types.
  - Retire, go to FETCH.
- HALT: absorbing state, all strobes 0; left only by reset.
- Retire: RETIRE_CNT increments by 1 on the exiting edge and wraps from all-ones to 0. Halt and illegal instructions do not retire.
- Outside the listed cases, every strobe and select is 0.

## Timing
- Reset (RST_N=0):
  - Takes effect immediately, including mid-instruction or mid-handshake.
  - STATE=FETCH and all strobes, selects and OP_ALU are 0.
  - ILLEGAL=0 and RETIRE_CNT=0.
  - An interrupted memory request is dropped.
- On the first CLK edge after RST_N rises, FETCH begins and IMEM_REQ=1.
- Minimum latency in cycles, with both READY inputs high on the first request cycle:
  - ALU reg-reg and ALU immediate: 4.
  - Load: 5.
  - Store: 4.
  - Branch and jump: 3.
  - Each wait cycle on a READY input adds 1.
- All outputs are Moore outputs of state plus the registered instruction fields.
- The READY inputs and COND gate only the strobes in their own state; they have no combinational path to any other output.
- A READY input asserted while its request is low is ignored.
- IMEM_READY and DMEM_READY are never both relevant in the same cycle.

## Test plan
- Reset mid-MEM: hold DMEM_READY=0 on a store and pulse RST_N low. All outputs must drop to 0 at once with STATE=0 and RETIRE_CNT=0. The next fetch begins on the first edge after release.
- ALU reg-reg, type 000 op 00011, both READY inputs always 1:
  - STATE sequence is 0,1,2,4,0.
  - OP_ALU=3 and W_RF=1 in EXEC only; W_RB=1 and S_MXRB=0 in WB.
  - RETIRE_CNT goes from 0 to 1.
- Load with DMEM_READY low for 3 MEM cycles:
  - DMEM_REQ is held 4 cycles with W_DM=0.
  - W_RB=1 and S_MXRB=1 in the WB cycle; total latency 8 cycles.
- Branch, type 100:
  - With COND=0: W_PC=0 in EXEC.
  - With COND=1: W_PC=1 and S_MXPC=1.
  - Either way the instruction retires after 3 cycles.
- IMEM stall then halt:
  - Hold IMEM_READY=0 for 5 cycles: IMEM_REQ stays 1 and W_MI fires once when READY rises.
  - A type 111 instruction then gives STATE=5 permanently with RETIRE_CNT unchanged.
- Illegal instruction and counter wrap:
  - Type 110 sets ILLEGAL=1, which holds in HALT.
  - Separately, preload 65535 retires, then one more retire gives RETIRE_CNT=0.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, waits on the memory ready handshakes, drives
// write strobes and mux selects, counts retired instructions and flags
// illegal opcodes.
module multicycle_sequencer #(
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [2:0]          INSTR_TYPE,
    input  logic [4:0]          INSTR_OP,
    input  logic                COND,
    input  logic                IMEM_READY,
    input  logic                DMEM_READY,
    output logic                IMEM_REQ,
    output logic                DMEM_REQ,
    output logic                W_MI,
    output logic                W_PC,
    output logic                W_RB,
    output logic                W_RF,
    output logic                W_DM,
    output logic                S_MXPC,
    output logic                S_MXRB,
    output logic                S_MXSE,
    output logic [4:0]          OP_ALU,
    output logic [2:0]          STATE,
    output logic                ILLEGAL,
    output logic [RETIRE_W-1:0] RETIRE_CNT
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] T_ALU_RR = 3'b000;
    localparam logic [2:0] T_ALU_IM = 3'b001;
    localparam logic [2:0] T_LOAD   = 3'b010;
    localparam logic [2:0] T_STORE  = 3'b011;
    localparam logic [2:0] T_BRANCH = 3'b100;
    localparam logic [2:0] T_JUMP   = 3'b101;
    localparam logic [2:0] T_ILLEGAL= 3'b110;
    localparam logic [2:0] T_HALT   = 3'b111;

    state_t                state;
    state_t                state_next;
    logic                  running;
    logic                  retire;
    logic                  set_illegal;
    logic                  illegal_q;
    logic [RETIRE_W-1:0]   retire_cnt;

    // Fetch is held off until the first edge after reset release, so the
    // request (and any READY it would qualify) stays low while in reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            running <= 1'b0;
        end else begin
            running <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Sticky illegal flag and retired-instruction counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            illegal_q  <= 1'b0;
            retire_cnt <= '0;
        end else begin
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (retire) begin
                retire_cnt <= retire_cnt + RETIRE_W'(1);
            end
        end
    end

    // Next-state decode and Moore strobes/selects per state.
    always_comb begin
        state_next  = state;
        retire      = 1'b0;
        set_illegal = 1'b0;
        IMEM_REQ    = 1'b0;
        DMEM_REQ    = 1'b0;
        W_MI        = 1'b0;
        W_PC        = 1'b0;
        W_RB        = 1'b0;
        W_RF        = 1'b0;
        W_DM        = 1'b0;
        S_MXPC      = 1'b0;
        S_MXRB      = 1'b0;
        S_MXSE      = 1'b0;
        OP_ALU      = '0;

        case (state)
            S_FETCH: begin
                if (running) begin
                    IMEM_REQ = 1'b1;
                    if (IMEM_READY) begin
                        W_MI       = 1'b1;
                        W_PC       = 1'b1;
                        state_next = S_DECODE;
                    end
                end
            end

            S_DECODE: begin
                case (INSTR_TYPE)
                    T_HALT:    state_next = S_HALT;
                    T_ILLEGAL: begin
                        set_illegal = 1'b1;
                        state_next  = S_HALT;
                    end
                    default:   state_next = S_EXEC;
                endcase
            end

            S_EXEC: begin
                OP_ALU = INSTR_OP;
                case (INSTR_TYPE)
                    T_ALU_RR: begin
                        W_RF       = 1'b1;
                        state_next = S_WB;
                    end
                    T_ALU_IM: begin
                        S_MXSE     = 1'b1;
                        W_RF       = 1'b1;
                        state_next = S_WB;
                    end
                    T_LOAD, T_STORE: begin
                        S_MXSE     = 1'b1;
                        state_next = S_MEM;
                    end
                    T_BRANCH: begin
                        S_MXPC     = 1'b1;
                        W_PC       = COND;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    T_JUMP: begin
                        S_MXPC     = 1'b1;
                        W_PC       = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    default: state_next = S_FETCH;
                endcase
            end

            S_MEM: begin
                DMEM_REQ = 1'b1;
                W_DM     = (INSTR_TYPE == T_STORE);
                if (DMEM_READY) begin
                    if (INSTR_TYPE == T_STORE) begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end

            S_WB: begin
                W_RB       = 1'b1;
                S_MXRB     = (INSTR_TYPE == T_LOAD);
                retire     = 1'b1;
                state_next = S_FETCH;
            end

            S_HALT: state_next = S_HALT;

            default: state_next = S_FETCH;
        endcase
    end

    assign STATE      = state;
    assign ILLEGAL    = illegal_q;
    assign RETIRE_CNT = retire_cnt;

endmodule
